// File: rtl/noc_wrr_packet_arbiter.sv
// Packet-aware weighted round-robin arbiter for a NoC router output port.
// Each owner holds the channel for whole packets (head through tail) and may
// send up to its weight in packets before the priority pointer moves on.
module noc_wrr_packet_arbiter #(
    parameter int NUM_AGENTS = 4,
    parameter int WEIGHT_W   = 4,
    parameter int IDX_W      = $clog2(NUM_AGENTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_AGENTS-1:0]          req,
    input  logic [NUM_AGENTS-1:0]          req_last,
    input  logic [NUM_AGENTS*WEIGHT_W-1:0] weight,
    input  logic                           out_ready,
    output logic [NUM_AGENTS-1:0]          grant,
    output logic                           grant_valid,
    output logic [IDX_W-1:0]               grant_idx,
    output logic                           xfer
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_AGENTS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]     credit_q, credit_d;
    logic                    in_pkt_q, in_pkt_d;

    logic                    found;
    logic [IDX_W-1:0]        winner;
    logic [WEIGHT_W-1:0]     win_weight;
    logic [WEIGHT_W-1:0]     w_arr [NUM_AGENTS];

    // A zero weight still grants one packet per turn.
    function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
        if (w == '0) begin
            return WEIGHT_W'(1);
        end
        return w;
    endfunction

    // Successor of an agent index, wrapping at NUM_AGENTS.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_AGENTS - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_idx   = idx_q;
    assign xfer        = grant_valid & req[idx_q] & out_ready;

    // Unpack the flat weight bus into per-agent fields.
    always_comb begin
        for (int i = 0; i < NUM_AGENTS; i++) begin
            w_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
        end
    end

    // Rotating-priority scan: first requester at or after the pointer wins.
    always_comb begin
        int               j;
        logic [IDX_W-1:0] jj;
        found      = 1'b0;
        winner     = '0;
        win_weight = '0;
        j          = 0;
        jj         = '0;
        for (int k = 0; k < NUM_AGENTS; k++) begin
            j  = (int'(ptr_q) + k) % NUM_AGENTS;
            jj = IDX_W'(j);
            if (!found && req[jj]) begin
                found      = 1'b1;
                winner     = jj;
                win_weight = w_arr[jj];
            end
        end
    end

    // Next-state logic: grant from IDLE, packet/credit tracking and release in OWN.
    always_comb begin
        logic                rel;
        logic [WEIGHT_W-1:0] credit_dec;
        state_d    = state_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        credit_d   = credit_q;
        in_pkt_d   = in_pkt_q;
        rel        = 1'b0;
        credit_dec = (credit_q != '0) ? credit_q - 1'b1 : '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d         = OWN;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    idx_d           = winner;
                    credit_d        = eff_weight(win_weight);
                    in_pkt_d        = 1'b0;
                end
            end
            OWN: begin
                if (xfer) begin
                    if (req_last[idx_q]) begin
                        in_pkt_d = 1'b0;
                        credit_d = credit_dec;
                        if (credit_dec == '0) begin
                            rel = 1'b1;
                        end
                    end else begin
                        in_pkt_d = 1'b1;
                    end
                end else if (!in_pkt_q && !req[idx_q]) begin
                    // Owner went quiet between packets: hand the channel back.
                    rel = 1'b1;
                end
                if (rel) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = next_idx(idx_q);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
            in_pkt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            in_pkt_q <= in_pkt_d;
        end
    end

endmodule

// File: tb/tb_noc_wrr_packet_arbiter.sv
// Directed bench for noc_wrr_packet_arbiter (4 agents, 4-bit weights).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_noc_wrr_packet_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  req_last;
    logic [15:0] weight;
    logic        out_ready;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_idx;
    logic        xfer;

    int checks = 0;
    int errors = 0;

    noc_wrr_packet_arbiter #(
        .NUM_AGENTS(4),
        .WEIGHT_W  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_last   (req_last),
        .weight     (weight),
        .out_ready  (out_ready),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx),
        .xfer       (xfer)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = '0;
        req_last  = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = '0;
        req_last  = '0;
        weight    = 16'h1111;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({grant, grant_valid, grant_idx, xfer} !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold got=%b want=%b", {grant, grant_valid, grant_idx, xfer}, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({grant, grant_valid, grant_idx, xfer} !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, {grant, grant_valid, grant_idx, xfer}, 8'h00);
            end
        end
    endtask

    task automatic test_basic_rr();
        logic [3:0] eg [11];
        logic [1:0] ei [11];
        logic [7:0] exp_v;
        eg = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
               4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        ei = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
        weight = 16'h1111;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            req       = (i < 10) ? 4'b1111 : 4'b0000;
            req_last  = 4'b1111;
            out_ready = 1'b1;
            #1;
            exp_v = {eg[i], (eg[i] != 4'b0), ei[i], (eg[i] != 4'b0)};
            checks++;
            if ({grant, grant_valid, grant_idx, xfer} !== exp_v) begin
                errors++;
                $display("FAIL basic_rr cyc=%0d got=%b want=%b", i, {grant, grant_valid, grant_idx, xfer}, exp_v);
            end
        end
    endtask

    task automatic test_packet_hold();
        logic [3:0] sreq [11];
        logic [3:0] slast [11];
        logic       sor [11];
        logic [3:0] eg [11];
        logic [1:0] ei [11];
        logic       ex [11];
        logic [7:0] exp_v;
        sreq  = '{4'b0100, 4'b1111, 4'b1111, 4'b1111, 4'b1011, 4'b1111,
                  4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
        slast = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                  4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        sor   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        eg    = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                  4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
        ei    = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
        ex    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        weight = 16'h1111;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            req       = sreq[i];
            req_last  = slast[i];
            out_ready = sor[i];
            #1;
            exp_v = {eg[i], (eg[i] != 4'b0), ei[i], ex[i]};
            checks++;
            if ({grant, grant_valid, grant_idx, xfer} !== exp_v) begin
                errors++;
                $display("FAIL packet_hold cyc=%0d got=%b want=%b", i, {grant, grant_valid, grant_idx, xfer}, exp_v);
            end
        end
    endtask

    task automatic test_weighted();
        logic [3:0] eg [13];
        logic [1:0] ei [13];
        logic [7:0] exp_v;
        eg = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
               4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
        ei = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        weight = 16'h1113;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            req       = (i < 12) ? 4'b0011 : 4'b0000;
            req_last  = 4'b0011;
            out_ready = 1'b1;
            #1;
            exp_v = {eg[i], (eg[i] != 4'b0), ei[i], (eg[i] != 4'b0)};
            checks++;
            if ({grant, grant_valid, grant_idx, xfer} !== exp_v) begin
                errors++;
                $display("FAIL weighted cyc=%0d got=%b want=%b", i, {grant, grant_valid, grant_idx, xfer}, exp_v);
            end
        end
    endtask

    task automatic test_zero_weight();
        logic [3:0] eg [7];
        logic [1:0] ei [7];
        logic [7:0] exp_v;
        eg = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
        ei = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
        weight = 16'h1110;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            req       = (i < 6) ? 4'b0011 : 4'b0000;
            req_last  = 4'b0011;
            out_ready = 1'b1;
            #1;
            exp_v = {eg[i], (eg[i] != 4'b0), ei[i], (eg[i] != 4'b0)};
            checks++;
            if ({grant, grant_valid, grant_idx, xfer} !== exp_v) begin
                errors++;
                $display("FAIL zero_weight cyc=%0d got=%b want=%b", i, {grant, grant_valid, grant_idx, xfer}, exp_v);
            end
        end
    endtask

    task automatic test_owner_idle_release();
        logic [3:0] sreq [6];
        logic [3:0] slast [6];
        logic [3:0] eg [6];
        logic [1:0] ei [6];
        logic       ex [6];
        logic [7:0] exp_v;
        sreq  = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        slast = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        eg    = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0100};
        ei    = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
        ex    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        weight = 16'h1131;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req       = sreq[i];
            req_last  = slast[i];
            out_ready = 1'b1;
            #1;
            exp_v = {eg[i], (eg[i] != 4'b0), ei[i], ex[i]};
            checks++;
            if ({grant, grant_valid, grant_idx, xfer} !== exp_v) begin
                errors++;
                $display("FAIL idle_release cyc=%0d got=%b want=%b", i, {grant, grant_valid, grant_idx, xfer}, exp_v);
            end
        end
    endtask

    task automatic test_async_reset_mid_packet();
        logic [3:0] sreq [5];
        logic [3:0] slast [5];
        logic       sor [5];
        logic [3:0] eg [5];
        logic [1:0] ei [5];
        logic       ex [5];
        logic [7:0] exp_v;
        sreq  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010};
        slast = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        sor   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        eg    = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0010};
        ei    = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        ex    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        weight = 16'h1111;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req       = sreq[i];
            req_last  = slast[i];
            out_ready = sor[i];
            #1;
            exp_v = {eg[i], (eg[i] != 4'b0), ei[i], ex[i]};
            checks++;
            if ({grant, grant_valid, grant_idx, xfer} !== exp_v) begin
                errors++;
                $display("FAIL arst_setup cyc=%0d got=%b want=%b", i, {grant, grant_valid, grant_idx, xfer}, exp_v);
            end
        end
        // Agent 1 is mid-packet and the pointer sits at 1; reset between edges.
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, grant_valid, grant_idx} !== 7'h00) begin
            errors++;
            $display("FAIL arst_immediate got=%b want=%b", {grant, grant_valid, grant_idx}, 7'h00);
        end
        @(negedge clk);
        req       = 4'b0011;
        req_last  = 4'b0011;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({grant, grant_valid, grant_idx, xfer} !== 8'h00) begin
            errors++;
            $display("FAIL arst_idle got=%b want=%b", {grant, grant_valid, grant_idx, xfer}, 8'h00);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({grant, grant_valid, grant_idx, xfer} !== {4'b0001, 1'b1, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL arst_regrant got=%b want=%b", {grant, grant_valid, grant_idx, xfer},
                     {4'b0001, 1'b1, 2'd0, 1'b1});
        end
    endtask

    initial begin
        test_reset();
        test_basic_rr();
        test_packet_hold();
        test_weighted();
        test_zero_weight();
        test_owner_idle_release();
        test_async_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
